serial_compare_ctrl: RTL and testbench
======================================

Name: serial_compare_ctrl

Overview:
- Sequencer that performs an N-bit magnitude compare using the ALU's 1-bit comparator cells, one bit per cycle, MSB first.
- Drives one bit pair per cycle to two external comparator instances, wired as gt = A&~B and lt = B&~A. Stops early on the first differing bit.
- Sits between the ALU control unit and the comparator cells. Supports unsigned and two's-complement operands, with a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; sampled only when not busy
- signed_mode  input  1  1 = two's-complement compare; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- cp_a  output  1  bit of A presented to the comparator cells
- cp_b  output  1  bit of B presented to the comparator cells
- cp_gt  input  1  combinational return from cell cp_a&~cp_b
- cp_lt  input  1  combinational return from cell cp_b&~cp_a
- busy  output  1  compare in progress
- done  output  1  one-cycle pulse; result valid
- gt  output  1  A > B, registered, held until next accepted start
- eq  output  1  A == B, registered, held
- lt  output  1  A < B, registered, held

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, gt, eq, lt, cp_a, cp_b all 0. Shift registers and bit index cleared. Reset mid-compare aborts with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE: on start=1 at a rising edge:
  - latch A, B, signed_mode;
  - set idx=WIDTH-1;
  - clear gt/eq/lt;
  - go to SCAN with busy=1.
- SCAN:
  - cp_a=A_reg[idx], cp_b=B_reg[idx], driven combinationally from registers.
  - cp_gt/cp_lt are evaluated in the same cycle.
  - Sign bit: if signed_mode=1 and idx=WIDTH-1, the sense is swapped: cp_gt=1 means A<B, cp_lt=1 means A>B.
  - If the (possibly swapped) gt or lt is set, register the result, go to DONE.
  - Else if idx=0, set eq=1 and go to DONE.
  - Else idx decrements.
  - If cp_gt and cp_lt are both 1 (cell fault), gt takes priority.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - start=1 while in DONE is accepted as a new compare, same as in IDLE.
  - That restart goes directly to SCAN; gt/eq/lt are cleared on that edge.
- start while busy=1 (SCAN) is ignored; operands are not re-sampled.
- Latency: first differing bit at position k gives done asserted (WIDTH-k)+1 cycles after the start edge.
  - MSB differs: done 2 cycles after start.
  - Equal operands: WIDTH+1 cycles.
- Result flags are one-hot whenever done=1 and remain stable until the next accepted start.
- cp_a/cp_b are 0 outside SCAN.

Test Plan:
- Reset, then WIDTH=8, unsigned, A=0x80, B=0x7F, start -> cp_a=1/cp_b=0 in first SCAN cycle; done 2 cycles after start; gt=1, eq=0, lt=0.
- Unsigned A=0x5A, B=0x5A -> 8 SCAN cycles; done at cycle 9; eq=1; gt=lt=0.
- Unsigned A=0x12, B=0x13 -> decided at bit 0; done at cycle 9; lt=1.
- Signed A=0xFF (-1), B=0x01 -> MSB swap applied; done at cycle 2; lt=1. Same operands unsigned -> gt=1.
- start pulsed during SCAN with different operands -> ignored; original result reported. start held high through DONE -> new compare begins the next cycle, with flags cleared on that edge.
- rst_n asserted low in the 3rd SCAN cycle -> all outputs 0 immediately; no done pulse; next start produces a correct result.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator sequencer: walks A/B MSB-first through external
// 1-bit comparator cells and stops on the first differing bit.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             cp_a,
  output logic             cp_b,
  input  logic             cp_gt,
  input  logic             cp_lt,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sgn_reg;
  logic [IDX_W-1:0] idx;
  logic             accept, swap, eff_gt, eff_lt;
  logic             hit_gt, hit_lt, hit_eq;

  // Handshake: start is a request taken on any rising edge where busy is low
  // (IDLE or DONE); each accepted request yields exactly one done pulse unless
  // rst_n intervenes. Requests seen while busy are dropped, not queued.
  assign accept = start && (state != SCAN);

  // The sign bit of a two's-complement operand carries negative weight, so a
  // 1 there means "smaller": swap the cell outputs on that bit only.
  assign swap   = sgn_reg && (idx == IDX_MSB);
  assign eff_gt = swap ? cp_lt : cp_gt;
  assign eff_lt = swap ? cp_gt : cp_lt;

  assign cp_a      = (state == SCAN) ? a_reg[idx] : 1'b0;
  assign cp_b      = (state == SCAN) ? b_reg[idx] : 1'b0;
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit_gt    = 1'b0;
    hit_lt    = 1'b0;
    hit_eq    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        // gt wins if a faulty cell raises both lines
        if (eff_gt) begin
          hit_gt    = 1'b1;
          state_nxt = DONE;
        end else if (eff_lt) begin
          hit_lt    = 1'b1;
          state_nxt = DONE;
        end else if (idx == '0) begin
          hit_eq    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
      idx     <= '0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B;
      sgn_reg <= signed_mode;
      idx     <= IDX_MSB;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else if (state == SCAN) begin
      if (hit_gt)      gt  <= 1'b1;
      else if (hit_lt) lt  <= 1'b1;
      else if (hit_eq) eq  <= 1'b1;
      else             idx <= idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (WIDTH=8) with a behavioural model of
// the two comparator cells and a cell_fault input that raises both cell outputs.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cp_a, cp_b, cp_gt, cp_lt;
  logic         busy, done, gt, eq, lt;
  logic [1:0]   dbg_state;
  logic         cell_fault = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic [2:0] exp_q[$];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  assign cp_gt = cell_fault | (cp_a & ~cp_b);
  assign cp_lt = cell_fault | (cp_b & ~cp_a);

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .A(a_in), .B(b_in), .cp_a(cp_a), .cp_b(cp_b), .cp_gt(cp_gt), .cp_lt(cp_lt),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .dbg_state(dbg_state)
  );

  // ---------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    a_in = a; b_in = b; signed_mode = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles with the first SCAN cycle as 1; gives up after a bound.
  task automatic wait_done(input string tag);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic [2:0] exp_flags, input int exp_cyc);
    exp_q.push_back(exp_flags);
    do_start(a, b, s);
    check({tag, "_cp_first"}, {30'd0, cp_a, cp_b}, {30'd0, a[W-1], b[W-1]});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(tag);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_flags"}, {29'd0, gt, eq, lt}, {29'd0, exp_q.pop_front()});
    check({tag, "_done_idle"}, {27'd0, busy, cp_a, cp_b, dbg_state}, {27'd0, 3'b000, 2'd2});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_hold"}, {29'd0, gt, eq, lt}, {29'd0, exp_flags});
  endtask

  // ---------------- scenarios
  initial begin
    int pulses;
    #12;
    check("reset_outs", {22'd0, busy, done, gt, eq, lt, cp_a, cp_b, dbg_state, 1'b0},
          32'd0);
    @(negedge clk); rst_n = 1'b1;

    // flags are {gt,eq,lt}
    run("msb_gt",   8'h80, 8'h7F, 1'b0, 3'b100, 2);
    run("equal",    8'h5A, 8'h5A, 1'b0, 3'b010, 9);
    run("bit0_lt",  8'h12, 8'h13, 1'b0, 3'b001, 9);
    run("s_neg_lt", 8'hFF, 8'h01, 1'b1, 3'b001, 2);
    run("u_ff_gt",  8'hFF, 8'h01, 1'b0, 3'b100, 2);
    run("s_pos_gt", 8'h7F, 8'h80, 1'b1, 3'b100, 2);
    run("s_m2_lt",  8'hFE, 8'hFF, 1'b1, 3'b001, 9);
    run("s_eq",     8'h81, 8'h81, 1'b1, 3'b010, 9);
    run("bit3_gt",  8'h48, 8'h40, 1'b0, 3'b100, 6);

    // start during SCAN with different operands is ignored
    do_start(8'h12, 8'h13, 1'b0);
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ign_latency", cyc, 32'd9);
    check("ign_flags", {29'd0, gt, eq, lt}, {29'd0, 3'b001});

    // start held through DONE restarts straight into SCAN with cleared flags
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'h01; b_in = 8'h02;
    @(posedge clk); #1;
    check("hold_first_done", {28'd0, done, gt, eq, lt}, {28'd0, 4'b1100});
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_restart", {27'd0, busy, done, gt, eq, lt}, {27'd0, 5'b10000});
    wait_done("hold2");
    check("hold2_latency", cyc, 32'd8);
    check("hold2_flags", {29'd0, gt, eq, lt}, {29'd0, 3'b001});

    // faulty cell raising both lines: gt wins
    @(negedge clk); cell_fault = 1'b1;
    run("fault_gt", 8'h00, 8'h00, 1'b0, 3'b100, 2);
    cell_fault = 1'b0;

    // reset in the third SCAN cycle aborts without a done pulse
    do_start(8'h12, 8'h13, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {24'd0, busy, done, gt, eq, lt, cp_a, cp_b, dbg_state[0]}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);
    run("post_reset", 8'h3C, 8'h3C, 1'b1, 3'b010, 9);
    run("post_reset2", 8'h03, 8'h83, 1'b1, 3'b100, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
